// File: rtl/clyde_rcst_seq_if.sv
// -----------------------------------------------------------------------------
// clyde_rcst_seq_if
// Handshake bundle between the Clyde round controller and the round-constant
// sequencer.
//   master (round controller): drives start, decrypt, abort, step;
//                              receives W, valid, last, done, busy (and err).
//   slave  (sequencer)       : the mirror image.
// Optional macro CLYDE_RCST_SELFCHECK_EN adds the sticky err flag.
// -----------------------------------------------------------------------------
interface clyde_rcst_seq_if;
    logic       start;
    logic       decrypt;
    logic       abort;
    logic       step;
    logic [3:0] W;
    logic       valid;
    logic       last;
    logic       done;
    logic       busy;
`ifdef CLYDE_RCST_SELFCHECK_EN
    logic       err;
`endif

    modport master (
        output start, decrypt, abort, step,
        input  W, valid, last, done, busy
`ifdef CLYDE_RCST_SELFCHECK_EN
        , input err
`endif
    );

    modport slave (
        input  start, decrypt, abort, step,
        output W, valid, last, done, busy
`ifdef CLYDE_RCST_SELFCHECK_EN
        , output err
`endif
    );
endinterface

// File: rtl/clyde_rcst_seq.sv
// -----------------------------------------------------------------------------
// clyde_rcst_seq
// Round-constant sequencer for the Clyde-128 datapath. Holds the 4-bit LFSR
// state and presents one public (unmasked) constant per round. Steps forward
// for encryption and backward (inverse LFSR) for decryption.
//
// Ports:
//   clk   - clock, rising edge
//   nrst  - asynchronous active-low reset
//   bus   - clyde_rcst_seq_if.slave:
//             start/decrypt/abort/step in; W/valid/last/done/busy out
//
// Optional macro CLYDE_RCST_SELFCHECK_EN: adds bus.err, a sticky flag that
// sets when a run ends on the wrong constant or RUN ever shows W==0.
// -----------------------------------------------------------------------------
module clyde_rcst_seq #(
    parameter int unsigned NROUNDS    = 12,
    parameter logic [3:0]  W_ENC_INIT = 4'h1,
    parameter logic [3:0]  W_DEC_INIT = 4'hE
) (
    input logic             clk,
    input logic             nrst,
    clyde_rcst_seq_if.slave bus
);
    localparam logic [3:0] LAST_CNT = 4'(NROUNDS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] w_q, w_d;
    logic       dir_q, dir_d;
    logic       done_q, done_d;

    function automatic logic [3:0] lfsr_fwd(input logic [3:0] w);
        return {w[2:0], 1'b0} ^ (w[3] ? 4'b0011 : 4'b0000);
    endfunction

    // Exact inverse of lfsr_fwd: undo the feedback XOR, shift back, restore
    // the bit that fell out of the top.
    function automatic logic [3:0] lfsr_bwd(input logic [3:0] w);
        logic [3:0] t;
        t = w ^ (w[0] ? 4'b0011 : 4'b0000);
        return (t >> 1) ^ (w[0] ? 4'b1000 : 4'b0000);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            w_q     <= W_ENC_INIT;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = RUN;
                    w_d     = bus.decrypt ? W_DEC_INIT : W_ENC_INIT;
                    dir_d   = bus.decrypt;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // abort wins over step; start is ignored while running.
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.step) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        w_d   = dir_q ? lfsr_bwd(w_q) : lfsr_fwd(w_q);
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // w_q keeps its value in IDLE; only the visible output is blanked.
    assign bus.valid = (state_q == RUN);
    assign bus.busy  = (state_q == RUN);
    assign bus.last  = (state_q == RUN) && (cnt_q == LAST_CNT);
    assign bus.W     = (state_q == RUN) ? w_q : 4'h0;
    assign bus.done  = done_q;

`ifdef CLYDE_RCST_SELFCHECK_EN
    logic err_q;
    logic err_set;
    logic [3:0] w_end;

    // Walking the full schedule must land on the other direction's start.
    assign w_end   = dir_q ? W_ENC_INIT : W_DEC_INIT;
    assign err_set = (state_q == RUN) && !bus.abort &&
                     ((w_q == 4'h0) ||
                      (bus.step && (cnt_q == LAST_CNT) && (w_q != w_end)));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) err_q <= 1'b0;
        else       err_q <= err_q | err_set;
    end

    assign bus.err = err_q;
`endif
endmodule
